// File: rtl/uart_cmd_pkg.sv
// uart_cmd_pkg
// Shared definitions for the UART command decoder: FSM state encoding,
// wire-format byte values, command type codes, argument counts and a
// saturating-increment helper for the error counter.
package uart_cmd_pkg;

  typedef enum logic [2:0] {
    ST_HUNT   = 3'd0,
    ST_OPCODE = 3'd1,
    ST_ARGS   = 3'd2,
    ST_CHECK  = 3'd3,
    ST_ISSUE  = 3'd4
  } state_e;

  localparam logic [7:0] SYNC_BYTE = 8'hA5;
  localparam logic [7:0] OP_PIXEL  = 8'h01;
  localparam logic [7:0] OP_FILL   = 8'h02;

  localparam logic [1:0] CMD_PIXEL = 2'd1;
  localparam logic [1:0] CMD_FILL  = 2'd2;

  // Argument byte counts for each opcode; PIXEL is also the storage depth.
  localparam int         ARGS_MAX   = 5;
  localparam logic [2:0] PIXEL_ARGS = 3'd5;
  localparam logic [2:0] FILL_ARGS  = 3'd1;

  // Counter increment that sticks at all-ones.
  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

endpackage

// File: rtl/uart_byte_strobe.sv
// uart_byte_strobe
// Turns the receiver's frame_valid (pulse or held level) into a single-cycle
// byte strobe using a registered rising-edge detect, and extracts the data
// byte from the 9-bit frame.
//   clk_16bd    in   16x-baud clock
//   rst         in   asynchronous, active-low reset
//   frame       in   received frame; bit 8 is not used
//   frame_valid in   receiver frame-valid
//   rx_byte     out  frame[7:0]
//   byte_stb    out  high for the one cycle in which a byte is accepted
module uart_byte_strobe (
  input  logic       clk_16bd,
  input  logic       rst,
  input  logic [8:0] frame,
  input  logic       frame_valid,
  output logic [7:0] rx_byte,
  output logic       byte_stb
);

  logic fv_q;
  logic fv_d;
  logic unused_frame_bit8;

  assign unused_frame_bit8 = frame[8];

  always_comb begin
    fv_d = frame_valid;
  end

  always_ff @(posedge clk_16bd or negedge rst) begin
    if (!rst) begin
      fv_q <= 1'b0;
    end else begin
      fv_q <= fv_d;
    end
  end

  // Accept in the same cycle frame_valid rises, so a held level yields one byte.
  assign byte_stb = frame_valid & ~fv_q;
  assign rx_byte  = frame[7:0];

endmodule

// File: rtl/uart_cmd_decoder.sv
// uart_cmd_decoder
// Assembles received bytes into framed, checksummed drawing commands
// (0xA5, OP, args, XOR checksum) and presents them on a valid/ready port.
// Malformed, timed-out and stalled-over traffic is dropped and counted.
//   clk_16bd    in   16x-baud clock
//   rst         in   asynchronous, active-low reset
//   frame       in   received frame (bits [7:0] used)
//   frame_valid in   receiver frame-valid, pulse or level
//   cmd_valid   out  command available
//   cmd_ready   in   downstream accepts the command
//   cmd_op      out  1 = PIXEL, 2 = FILL
//   cmd_x/cmd_y out  pixel coordinates (0 for FILL)
//   cmd_color   out  colour byte
//   err_count   out  dropped-command counter, saturating at 255
module uart_cmd_decoder
  import uart_cmd_pkg::*;
#(
  parameter int H_RES       = 640,
  parameter int V_RES       = 480,
  parameter int TIMEOUT_CYC = 1024
) (
  input  logic       clk_16bd,
  input  logic       rst,
  input  logic [8:0] frame,
  input  logic       frame_valid,
  output logic       cmd_valid,
  input  logic       cmd_ready,
  output logic [1:0] cmd_op,
  output logic [9:0] cmd_x,
  output logic [9:0] cmd_y,
  output logic [7:0] cmd_color,
  output logic [7:0] err_count
);

  localparam int              TW       = $clog2(TIMEOUT_CYC);
  localparam logic [TW-1:0]   TMO_LAST = TW'(TIMEOUT_CYC - 1);
  localparam logic [10:0]     X_LIM    = 11'(H_RES);
  localparam logic [10:0]     Y_LIM    = 11'(V_RES);

  logic [7:0] rx_byte;
  logic       byte_stb;

  uart_byte_strobe u_strobe (
    .clk_16bd    (clk_16bd),
    .rst         (rst),
    .frame       (frame),
    .frame_valid (frame_valid),
    .rx_byte     (rx_byte),
    .byte_stb    (byte_stb)
  );

  state_e                   state_q, state_d;
  logic [7:0]               xor_q, xor_d;
  logic [2:0]               arg_idx_q, arg_idx_d;
  logic [2:0]               arg_last_q, arg_last_d;
  logic                     is_pixel_q, is_pixel_d;
  logic [ARGS_MAX-1:0][7:0] args_q, args_d;
  logic [TW-1:0]            tmo_q, tmo_d;
  logic [7:0]               err_q, err_d;
  logic [1:0]               op_q, op_d;
  logic [9:0]               x_q, x_d;
  logic [9:0]               y_q, y_d;
  logic [7:0]               color_q, color_d;

  logic       err_flag;
  logic       timed;
  logic       timeout;
  logic [9:0] pix_x;
  logic [9:0] pix_y;
  logic       in_range;
  logic       chk_ok;

  // Only the low two bits of XH/YH carry coordinate data.
  assign pix_x    = {args_q[0][1:0], args_q[1]};
  assign pix_y    = {args_q[2][1:0], args_q[3]};
  assign in_range = ({1'b0, pix_x} < X_LIM) && ({1'b0, pix_y} < Y_LIM);
  assign chk_ok   = (rx_byte == xor_q) && (!is_pixel_q || in_range);

  assign timed   = (state_q == ST_OPCODE) || (state_q == ST_ARGS) || (state_q == ST_CHECK);
  // An accepted byte in the expiry cycle takes priority over the timeout.
  assign timeout = timed && !byte_stb && (tmo_q == TMO_LAST);

  always_comb begin
    state_d    = state_q;
    xor_d      = xor_q;
    arg_idx_d  = arg_idx_q;
    arg_last_d = arg_last_q;
    is_pixel_d = is_pixel_q;
    args_d     = args_q;
    tmo_d      = '0;
    op_d       = op_q;
    x_d        = x_q;
    y_d        = y_q;
    color_d    = color_q;
    err_flag   = 1'b0;

    if (timed && !byte_stb) begin
      tmo_d = tmo_q + 1'b1;
    end

    case (state_q)
      ST_HUNT: begin
        if (byte_stb && rx_byte == SYNC_BYTE) begin
          state_d = ST_OPCODE;
        end
      end
      ST_OPCODE: begin
        if (byte_stb) begin
          xor_d     = rx_byte;
          arg_idx_d = '0;
          if (rx_byte == OP_PIXEL) begin
            is_pixel_d = 1'b1;
            arg_last_d = PIXEL_ARGS - 3'd1;
            state_d    = ST_ARGS;
          end else if (rx_byte == OP_FILL) begin
            is_pixel_d = 1'b0;
            arg_last_d = FILL_ARGS - 3'd1;
            state_d    = ST_ARGS;
          end else begin
            err_flag = 1'b1;
            state_d  = ST_HUNT;
          end
        end
      end
      ST_ARGS: begin
        // 0xA5 here is payload; no resync inside a command.
        if (byte_stb) begin
          args_d[arg_idx_q] = rx_byte;
          xor_d             = xor_q ^ rx_byte;
          if (arg_idx_q == arg_last_q) begin
            state_d = ST_CHECK;
          end else begin
            arg_idx_d = arg_idx_q + 3'd1;
          end
        end
      end
      ST_CHECK: begin
        if (byte_stb) begin
          if (chk_ok) begin
            state_d = ST_ISSUE;
            if (is_pixel_q) begin
              op_d    = CMD_PIXEL;
              x_d     = pix_x;
              y_d     = pix_y;
              color_d = args_q[4];
            end else begin
              op_d    = CMD_FILL;
              x_d     = '0;
              y_d     = '0;
              color_d = args_q[0];
            end
          end else begin
            err_flag = 1'b1;
            state_d  = ST_HUNT;
          end
        end
      end
      ST_ISSUE: begin
        // Nothing is buffered while a command waits, so new bytes are lost.
        if (byte_stb) begin
          err_flag = 1'b1;
        end
        if (cmd_ready) begin
          state_d = ST_HUNT;
        end
      end
      default: begin
        state_d = ST_HUNT;
      end
    endcase

    if (timeout) begin
      err_flag = 1'b1;
      state_d  = ST_HUNT;
    end

    if (state_d == ST_HUNT) begin
      xor_d     = '0;
      arg_idx_d = '0;
    end

    err_d = err_flag ? sat_inc8(err_q) : err_q;
  end

  always_ff @(posedge clk_16bd or negedge rst) begin
    if (!rst) begin
      state_q    <= ST_HUNT;
      xor_q      <= '0;
      arg_idx_q  <= '0;
      arg_last_q <= '0;
      is_pixel_q <= 1'b0;
      args_q     <= '0;
      tmo_q      <= '0;
      err_q      <= '0;
      op_q       <= '0;
      x_q        <= '0;
      y_q        <= '0;
      color_q    <= '0;
    end else begin
      state_q    <= state_d;
      xor_q      <= xor_d;
      arg_idx_q  <= arg_idx_d;
      arg_last_q <= arg_last_d;
      is_pixel_q <= is_pixel_d;
      args_q     <= args_d;
      tmo_q      <= tmo_d;
      err_q      <= err_d;
      op_q       <= op_d;
      x_q        <= x_d;
      y_q        <= y_d;
      color_q    <= color_d;
    end
  end

  assign cmd_valid = (state_q == ST_ISSUE);
  assign cmd_op    = op_q;
  assign cmd_x     = x_q;
  assign cmd_y     = y_q;
  assign cmd_color = color_q;
  assign err_count = err_q;

endmodule

// File: tb/tb_uart_cmd_decoder.sv
module tb_uart_cmd_decoder;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [8:0] frame = '0;
  logic       frame_valid = 1'b0;
  logic       cmd_ready = 1'b0;
  logic       cmd_valid;
  logic [1:0] cmd_op;
  logic [9:0] cmd_x;
  logic [9:0] cmd_y;
  logic [7:0] cmd_color;
  logic [7:0] err_count;

  int n_checks = 0;
  int n_fail   = 0;
  int pulse_cnt = 0;

  always #5 clk = ~clk;

  uart_cmd_decoder dut (
    .clk_16bd    (clk),
    .rst         (rst_n),
    .frame       (frame),
    .frame_valid (frame_valid),
    .cmd_valid   (cmd_valid),
    .cmd_ready   (cmd_ready),
    .cmd_op      (cmd_op),
    .cmd_x       (cmd_x),
    .cmd_y       (cmd_y),
    .cmd_color   (cmd_color),
    .err_count   (err_count)
  );

  typedef struct {
    int         len;
    logic [7:0] b [8];
    bit         v;
    int         op;
    int         x;
    int         y;
    int         color;
    int         err;
  } vec_t;

  vec_t vt [10];

  task automatic check(input string nm, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  // All waiting goes through here; inputs change and outputs are read at negedge.
  task automatic tick();
    @(negedge clk);
    if (cmd_valid) pulse_cnt++;
  endtask

  task automatic do_reset();
    frame_valid = 1'b0;
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    pulse_cnt = 0;
  endtask

  task automatic send_byte(input logic [7:0] b, output bit v_after);
    frame = {1'b0, b};
    frame_valid = 1'b1;
    tick();
    v_after = cmd_valid;
    frame_valid = 1'b0;
    tick();
  endtask

  task automatic check_fields(input string tag, input int op, input int x, input int y, input int c);
    check({tag, ".op"}, int'(cmd_op), op);
    check({tag, ".x"}, int'(cmd_x), x);
    check({tag, ".y"}, int'(cmd_y), y);
    check({tag, ".color"}, int'(cmd_color), c);
  endtask

  // ---------------- behavioural reference model for random traffic ----------------
  logic [7:0] cur [$];
  logic [7:0] sq  [$];
  bit m_hunting, m_pending;
  int m_err, m_op, m_x, m_y, m_color;

  task automatic model_byte(input logic [7:0] b);
    int nargs;
    logic [7:0] chk;
    int px, py;
    if (m_pending) begin
      if (m_err < 255) m_err++;
    end else if (m_hunting) begin
      if (b == 8'hA5) begin
        m_hunting = 0;
        cur.delete();
      end
    end else begin
      cur.push_back(b);
      if (cur[0] != 8'h01 && cur[0] != 8'h02) begin
        if (m_err < 255) m_err++;
        m_hunting = 1;
      end else begin
        nargs = (cur[0] == 8'h01) ? 5 : 1;
        if (cur.size() == nargs + 2) begin
          chk = 8'h00;
          for (int i = 0; i <= nargs; i++) chk ^= cur[i];
          px = (cur[0] == 8'h01) ? (cur[1] % 4) * 256 + cur[2] : 0;
          py = (cur[0] == 8'h01) ? (cur[3] % 4) * 256 + cur[4] : 0;
          if (chk == cur[nargs + 1] && px < 640 && py < 480) begin
            m_pending = 1;
            m_op = (cur[0] == 8'h01) ? 1 : 2;
            m_x = px;
            m_y = py;
            m_color = cur[nargs];
          end else begin
            if (m_err < 255) m_err++;
          end
          m_hunting = 1;
        end
      end
    end
  endtask

  task automatic gen_chunk();
    int r, x, y;
    logic [7:0] bs [$];
    logic [7:0] c;
    r = $urandom_range(0, 9);
    if (r <= 4 || r == 9) begin
      x = (r == 9) ? $urandom_range(0, 1023) : $urandom_range(0, 639);
      y = (r == 9) ? $urandom_range(0, 1023) : $urandom_range(0, 479);
      bs.push_back(8'h01);
      bs.push_back(8'(($urandom_range(0, 63) * 4) + x / 256));
      bs.push_back(8'(x % 256));
      bs.push_back(8'(($urandom_range(0, 63) * 4) + y / 256));
      bs.push_back(8'(y % 256));
      bs.push_back(8'($urandom_range(0, 255)));
    end else if (r <= 7) begin
      bs.push_back(8'h02);
      bs.push_back(8'($urandom_range(0, 255)));
    end else begin
      for (int i = 0; i < $urandom_range(1, 3); i++) sq.push_back(8'($urandom_range(0, 255)));
      return;
    end
    c = 8'h00;
    foreach (bs[i]) c ^= bs[i];
    if (r == 7) c ^= 8'($urandom_range(1, 255));
    sq.push_back(8'hA5);
    foreach (bs[i]) sq.push_back(bs[i]);
    sq.push_back(c);
  endtask

  initial begin
    bit v;
    bit nfv, stb, rdy, was_p;
    logic [7:0] b;

    // len, bytes, valid, op, x, y, color, err_count after
    vt[0] = '{8, '{8'hA5,8'h01,8'h01,8'h2C,8'h00,8'hF0,8'h1F,8'hC3}, 1, 1, 300, 240, 8'h1F, 0};
    vt[1] = '{4, '{8'hA5,8'h02,8'hE0,8'hE2,8'h00,8'h00,8'h00,8'h00}, 1, 2, 0, 0, 8'hE0, 0};
    vt[2] = '{4, '{8'hA5,8'h02,8'hE0,8'h00,8'h00,8'h00,8'h00,8'h00}, 0, 0, 0, 0, 0, 1};
    vt[3] = '{8, '{8'hA5,8'h01,8'h02,8'h80,8'h00,8'h00,8'h07,8'h84}, 0, 0, 0, 0, 0, 1};
    vt[4] = '{7, '{8'h00,8'hFF,8'h13,8'hA5,8'h02,8'hE0,8'hE2,8'h00}, 1, 2, 0, 0, 8'hE0, 0};
    vt[5] = '{2, '{8'hA5,8'h07,8'h00,8'h00,8'h00,8'h00,8'h00,8'h00}, 0, 0, 0, 0, 0, 1};
    vt[6] = '{8, '{8'hA5,8'h01,8'h02,8'h7F,8'h01,8'hDF,8'h55,8'hF7}, 1, 1, 639, 479, 8'h55, 0};
    vt[7] = '{8, '{8'hA5,8'h01,8'h00,8'h00,8'h01,8'hE0,8'h00,8'hE0}, 0, 0, 0, 0, 0, 1};
    vt[8] = '{8, '{8'hA5,8'h01,8'hFD,8'h2C,8'hFC,8'hF0,8'h1F,8'hC3}, 1, 1, 300, 240, 8'h1F, 0};
    vt[9] = '{4, '{8'hA5,8'h02,8'hA5,8'hA7,8'h00,8'h00,8'h00,8'h00}, 1, 2, 0, 0, 8'hA5, 0};

    // Reset values
    tick();
    check("rst.valid", int'(cmd_valid), 0);
    check("rst.err", int'(err_count), 0);
    check_fields("rst", 0, 0, 0, 0);

    // Table-driven single commands, ready held high
    foreach (vt[k]) begin
      do_reset();
      cmd_ready = 1'b1;
      for (int i = 0; i < vt[k].len; i++) send_byte(vt[k].b[i], v);
      check($sformatf("vec%0d.latency", k), int'(v), int'(vt[k].v));
      repeat (4) tick();
      check($sformatf("vec%0d.pulses", k), pulse_cnt, int'(vt[k].v));
      check($sformatf("vec%0d.valid_end", k), int'(cmd_valid), 0);
      check($sformatf("vec%0d.err", k), int'(err_count), vt[k].err);
      check_fields($sformatf("vec%0d", k), vt[k].op, vt[k].x, vt[k].y, vt[k].color);
      $display("vec %0d: op=%0d x=%0d y=%0d color=%02h err=%0d pulses=%0d",
               k, cmd_op, cmd_x, cmd_y, cmd_color, err_count, pulse_cnt);
    end

    // FILL stalled for 20 cycles with two bytes dropped meanwhile
    do_reset();
    cmd_ready = 1'b0;
    send_byte(8'hA5, v); send_byte(8'h02, v); send_byte(8'hE0, v); send_byte(8'hE2, v);
    for (int i = 0; i < 20; i++) begin
      if (i == 3 || i == 9) begin
        frame = (i == 3) ? 9'h055 : 9'h0A5;
        frame_valid = 1'b1;
      end else begin
        frame_valid = 1'b0;
      end
      tick();
      check("stall.valid", int'(cmd_valid), 1);
      check("stall.op", int'(cmd_op), 2);
      check("stall.color", int'(cmd_color), 8'hE0);
    end
    check("stall.err", int'(err_count), 2);
    cmd_ready = 1'b1;
    tick();
    check("stall.valid_after", int'(cmd_valid), 0);
    check_fields("stall.hold", 2, 0, 0, 8'hE0);
    $display("stall: err=%0d valid=%0d", err_count, cmd_valid);

    // Back-to-back PIXEL then FILL
    do_reset();
    cmd_ready = 1'b1;
    for (int i = 0; i < 8; i++) send_byte(vt[0].b[i], v);
    for (int i = 0; i < 4; i++) send_byte(vt[1].b[i], v);
    check("b2b.latency", int'(v), 1);
    repeat (3) tick();
    check("b2b.pulses", pulse_cnt, 2);
    check("b2b.err", int'(err_count), 0);
    check_fields("b2b", 2, 0, 0, 8'hE0);
    $display("b2b: pulses=%0d err=%0d", pulse_cnt, err_count);

    // Timeout after A5 01, then a full command
    do_reset();
    send_byte(8'hA5, v); send_byte(8'h01, v);
    repeat (1030) tick();
    check("tmo.err", int'(err_count), 1);
    for (int i = 0; i < 8; i++) send_byte(vt[0].b[i], v);
    check("tmo.recover", int'(v), 1);
    check_fields("tmo", 1, 300, 240, 8'h1F);
    $display("timeout: err=%0d recovered=%0d", err_count, v);

    // Long but sub-limit gap does not time out
    do_reset();
    send_byte(8'hA5, v); send_byte(8'h02, v);
    repeat (1000) tick();
    send_byte(8'hE0, v); send_byte(8'hE2, v);
    check("gap.valid", int'(v), 1);
    check("gap.err", int'(err_count), 0);
    $display("gap: valid=%0d err=%0d", v, err_count);

    // Level-held frame_valid counts once
    do_reset();
    frame = 9'h1A5;
    frame_valid = 1'b1;
    repeat (6) tick();
    frame_valid = 1'b0;
    tick();
    send_byte(8'h02, v); send_byte(8'hE0, v); send_byte(8'hE2, v);
    check("level.valid", int'(v), 1);
    check("level.err", int'(err_count), 0);
    $display("level: valid=%0d err=%0d", v, err_count);

    // Asynchronous reset mid-ARGS
    do_reset();
    send_byte(8'hA5, v); send_byte(8'h07, v);
    for (int i = 0; i < 4; i++) send_byte(vt[1].b[i], v);
    tick();
    send_byte(8'hA5, v); send_byte(8'h01, v); send_byte(8'h01, v); send_byte(8'h2C, v);
    #2 rst_n = 1'b0;
    #1;
    check("arst.valid", int'(cmd_valid), 0);
    check("arst.err", int'(err_count), 0);
    check_fields("arst", 0, 0, 0, 0);
    tick();
    rst_n = 1'b1;
    pulse_cnt = 0;
    tick();
    send_byte(8'h00, v); send_byte(8'hF0, v); send_byte(8'h1F, v); send_byte(8'hC3, v);
    repeat (3) tick();
    check("arst.pulses", pulse_cnt, 0);
    check("arst.err_after", int'(err_count), 0);
    $display("async reset: pulses=%0d err=%0d", pulse_cnt, err_count);

    // Error counter saturation
    do_reset();
    for (int i = 1; i <= 300; i++) begin
      send_byte(8'hA5, v); send_byte(8'h07, v);
      if (i == 254 || i == 255 || i == 300)
        check($sformatf("sat.after%0d", i), int'(err_count), (i < 255) ? i : 255);
    end
    $display("saturation: err=%0d", err_count);

    // Randomized traffic against the reference model
    do_reset();
    cur.delete();
    sq.delete();
    m_hunting = 1; m_pending = 0; m_err = 0;
    m_op = 0; m_x = 0; m_y = 0; m_color = 0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      check("rnd.valid", int'(cmd_valid), int'(m_pending));
      check("rnd.err", int'(err_count), m_err);
      check_fields("rnd", m_op, m_x, m_y, m_color);
      if (sq.size() == 0) gen_chunk();
      if (frame_valid) nfv = ($urandom_range(0, 2) == 0);
      else             nfv = ($urandom_range(0, 1) == 1);
      stb = nfv && !frame_valid;
      rdy = ($urandom_range(0, 3) != 0);
      cmd_ready = rdy;
      was_p = m_pending;
      if (stb) begin
        b = sq.pop_front();
        frame = {1'($urandom_range(0, 1)), b};
        model_byte(b);
      end
      if (was_p && rdy) begin
        m_pending = 0;
      end
      frame_valid = nfv;
      tick();
    end
    $display("random: err=%0d last op=%0d x=%0d y=%0d color=%02h", err_count, cmd_op, cmd_x, cmd_y, cmd_color);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
